// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scroll path.
// Digit entries are {dot, nibble}; every nibble code is a glyph (no blank code).
package seg_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SCROLL = 1'b1;

  localparam int SEG_ENTRY_W = 5;
  localparam int SEG_NIB_LSB = 0;
  localparam int SEG_NIB_W   = 4;
  localparam int SEG_DOT_BIT = 4;

  typedef logic [SEG_ENTRY_W-1:0] seg_entry_t;

  function automatic seg_entry_t seg_pack(
    input logic       dot,
    input logic [3:0] nib
  );
    return {dot, nib};
  endfunction

  function automatic logic [3:0] seg_nib(input seg_entry_t e);
    return e[SEG_NIB_LSB +: SEG_NIB_W];
  endfunction

  function automatic logic seg_dot(input seg_entry_t e);
    return e[SEG_DOT_BIT];
  endfunction

endpackage

// File: rtl/seg_scroll_ctrl_step_timer.sv
// Free-running step divider: counts 0..STEP_CYCLES-1 while enabled,
// emitting a one-cycle tick on the terminal count.
module seg_step_timer #(
  parameter int STEP_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scroll_ctrl.sv
// Message sequencer scrolling a 4-digit window over a loaded hex message.
// Optional SEG_SCROLL_PAUSE_EN adds a pause input that freezes stepping.
module seg_scroll_ctrl
  import seg_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int STEP_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_nibble,
  input  logic       wr_dot,
  input  logic       wr_last,
  input  logic       loop,
  input  logic       stop,
`ifdef SEG_SCROLL_PAUSE_EN
  input  logic       pause,
`endif
  output logic       busy,
  output logic       done,
  output logic [3:0] val3,
  output logic [3:0] val2,
  output logic [3:0] val1,
  output logic [3:0] val0,
  output logic       dot3,
  output logic       dot2,
  output logic       dot1,
  output logic       dot0
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [LW-1:0] len_t;

  logic [0:0] state_q, state_d;
  len_t       len_q, len_d;
  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       p_q [4];
  ptr_t       p_d [4];
  logic       fin_q, fin_d;
  logic       done_q, done_d;
  logic       loop_q, rdy_q, enter;
  logic [3:0] val_q [4];
  logic [3:0] dot_q;
  seg_entry_t buf_q [DEPTH];

  logic scroll, run, tick, adv, beat, full;

  // k mod n for k<=3 with small n, by repeated conditional subtract
  function automatic ptr_t wrap_k(input len_t k, input len_t n);
    len_t x;
    x = k;
    for (int i = 0; i < 3; i++)
      if (x >= n) x = x - n;
    return x[PW-1:0];
  endfunction

  assign scroll = (state_q == ST_SCROLL);
`ifdef SEG_SCROLL_PAUSE_EN
  assign run = scroll && !pause;
`else
  assign run = scroll;
`endif
  assign adv  = tick && !stop;
  assign beat = wr_valid && rdy_q && !scroll;
  assign full = (wr_ptr_q == ptr_t'(DEPTH - 1));

  seg_step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .en_i  (run),
    .clr_i (!scroll),
    .tick_o(tick)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr_ptr_d = wr_ptr_q;
    p_d      = p_q;
    fin_d    = fin_q;
    done_d   = 1'b0;
    enter    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (beat) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          len_d    = {1'b0, wr_ptr_q} + 1'b1;
          if (wr_last || full) begin
            enter    = 1'b1;
            state_d  = ST_SCROLL;
            wr_ptr_d = '0;
            fin_d    = 1'b0;
            p_d[3]   = '0;
            p_d[2]   = wrap_k(LW'(1), len_d);
            p_d[1]   = wrap_k(LW'(2), len_d);
            p_d[0]   = wrap_k(LW'(3), len_d);
          end
        end
      end
      default: begin
        if (stop) begin
          state_d  = ST_IDLE;
          len_d    = '0;
          wr_ptr_d = '0;
          fin_d    = 1'b0;
        end else if (fin_q) begin
          // one extra SCROLL cycle lets the window show the home position
          state_d = ST_IDLE;
          done_d  = 1'b1;
          len_d   = '0;
          fin_d   = 1'b0;
        end else if (adv) begin
          for (int k = 0; k < 4; k++)
            p_d[k] = ({1'b0, p_q[k]} == len_q - 1'b1) ? '0 : p_q[k] + 1'b1;
          if (({1'b0, p_q[3]} == len_q - 1'b1) && !loop_q)
            fin_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      wr_ptr_q <= '0;
      fin_q    <= 1'b0;
      done_q   <= 1'b0;
      loop_q   <= 1'b0;
      rdy_q    <= 1'b0;
      for (int k = 0; k < 4; k++) p_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wr_ptr_q <= wr_ptr_d;
      fin_q    <= fin_d;
      done_q   <= done_d;
      rdy_q    <= (state_d == ST_IDLE);
      p_q      <= p_d;
      if (enter) loop_q <= loop;
    end
  end

  always_ff @(posedge clk) begin
    if (beat) buf_q[wr_ptr_q] <= seg_pack(wr_dot, wr_nibble);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) val_q[k] <= '0;
      dot_q <= '0;
    end else if (scroll && !stop) begin
      for (int k = 0; k < 4; k++) begin
        val_q[k] <= seg_nib(buf_q[p_q[k]]);
        dot_q[k] <= seg_dot(buf_q[p_q[k]]);
      end
    end
  end

  assign wr_ready = rdy_q;
  assign busy     = scroll;
  assign done     = done_q;
  assign val3     = val_q[3];
  assign val2     = val_q[2];
  assign val1     = val_q[1];
  assign val0     = val_q[0];
  assign dot3     = dot_q[3];
  assign dot2     = dot_q[2];
  assign dot1     = dot_q[1];
  assign dot0     = dot_q[0];

endmodule
